// File: rtl/sub_scheduler_if.sv
// Request/response bundle between the requesters/consumer and the
// subtractor scheduler. The master side is the environment, the slave
// side is the scheduler.
interface sub_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_sub;
  logic              rsp_flag;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sub, rsp_flag
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sub, rsp_flag
  );
endinterface

// File: rtl/sub_scheduler.sv
// Round-robin scheduler sharing one 4-bit signed subtractor among NREQ
// requesters, with a saturating count of overflowed results.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grants the round-robin winner
// EXEC  | registered operands drive the subtractor; result captured
// RESP  | response held on rsp_* until the consumer takes it

// 4-bit signed subtractor; flag is 1 when a - b fits in 4 bits.
module subtratorcompleto_DUV (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sub,
  output logic       flag
);
  assign sub  = a - b;
  assign flag = ~((a[3] ^ b[3]) & (sub[3] ^ a[3]));
endmodule

module sub_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  sub_scheduler_if.slave  bus,
  output logic            busy,
  output logic [CNTW-1:0] ovf_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic [IDW-1:0]    ptr;
  logic [3:0]        a_q, b_q;
  logic [IDW-1:0]    id_q;
  logic              rsp_valid_q, rsp_flag_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [3:0]        rsp_sub_q;
  logic [CNTW-1:0]   ovf_q;

  logic              found;
  int                win_idx;
  logic [3:0]        a_sel, b_sel;
  logic [IDW-1:0]    win, ptr_nxt;
  logic [NREQ-1:0]   grant;
  logic              cap_en, exec_en;
  logic [3:0]        sub_w;
  logic              flag_w;

  subtratorcompleto_DUV u_sub (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_w),
    .flag (flag_w)
  );

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    logic [NREQ-1:0]   v_sh;
    logic [4*NREQ-1:0] a_sh, b_sh;
    found   = 1'b0;
    win_idx = 0;
    idx     = 0;
    v_sh    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      v_sh = bus.req_valid >> idx;
      if (!found && v_sh[0]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    a_sh    = bus.req_a >> (4 * win_idx);
    b_sh    = bus.req_b >> (4 * win_idx);
    a_sel   = a_sh[3:0];
    b_sel   = b_sh[3:0];
    win     = IDW'(win_idx);
    ptr_nxt = (win_idx == NREQ - 1) ? '0 : IDW'(win_idx + 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    cap_en    = 1'b0;
    exec_en   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant     = NREQ'(1) << win_idx;
          cap_en    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        exec_en   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, result registers and overflow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sub_q   <= '0;
      rsp_flag_q  <= 1'b0;
      ovf_q       <= '0;
    end else begin
      if (cap_en) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= win;
        ptr  <= ptr_nxt;
      end
      if (exec_en) begin
        rsp_sub_q   <= sub_w;
        rsp_flag_q  <= flag_w;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
        if (!flag_w && ovf_q != {CNTW{1'b1}}) ovf_q <= ovf_q + CNTW'(1);
      end else if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Grant is forced low while reset is asserted so nothing is accepted.
  assign bus.req_ready = rst ? '0 : grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sub   = rsp_sub_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign busy          = (state != IDLE) && !rst;
  assign ovf_count     = ovf_q;

endmodule

// File: tb/tb_sub_scheduler.sv
// Directed bench for sub_scheduler: expected responses are queued when a
// grant is observed and compared when the response appears.
module tb_sub_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0, busy1;
  logic [7:0] ovf0;
  logic [1:0] ovf1;

  sub_scheduler_if #(.NREQ(4), .IDW(3)) if0 ();
  sub_scheduler_if #(.NREQ(4), .IDW(3)) if1 ();

  sub_scheduler #(.NREQ(4), .IDW(3), .CNTW(8)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0), .ovf_count(ovf0)
  );
  sub_scheduler #(.NREQ(4), .IDW(3), .CNTW(2)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .busy(busy1), .ovf_count(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [3:0] sub;
    logic       flag;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_ovf0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic signed [3:0] sa, sbv;
    int r;
    sa     = a;
    sbv    = b;
    r      = int'(sa) - int'(sbv);
    e.id   = 3'(id);
    e.sub  = 4'(r);
    e.flag = (r >= -8) && (r <= 7);
    return e;
  endfunction

  task automatic push_exp(input int id, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e = model(id, a, b);
    if (!e.flag && exp_ovf0 < 255) exp_ovf0++;
    sbq.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    n_assert++;
    assert (sbq.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.sb_empty: observed=response expected=none", tag);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, ".valid"}, 32'(if0.rsp_valid), 32'd1);
      check({tag, ".id"},    32'(if0.rsp_id),    32'(e.id));
      check({tag, ".sub"},   32'(if0.rsp_sub),   32'(e.sub));
      check({tag, ".flag"},  32'(if0.rsp_flag),  32'(e.flag));
      check({tag, ".ovf"},   32'(ovf0),          32'(exp_ovf0));
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
    if0.req_valid[id]    = 1'b1;
    if0.req_a[4*id +: 4] = a;
    if0.req_b[4*id +: 4] = b;
  endtask

  task automatic clr_req(input int id);
    if0.req_valid[id] = 1'b0;
  endtask

  // One complete operation from IDLE with the consumer always ready.
  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input string tag);
    if0.rsp_ready = 1'b1;
    set_req(id, a, b);
    #1;
    check({tag, ".grant"}, 32'(if0.req_ready), 32'(1) << id);
    push_exp(id, a, b);
    tick();
    clr_req(id);
    check({tag, ".busy_exec"}, 32'(busy0), 32'd1);
    check({tag, ".novalid_exec"}, 32'(if0.rsp_valid), 32'd0);
    tick();
    check_rsp(tag);
    tick();
    check({tag, ".idle_busy"}, 32'(busy0), 32'd0);
    check({tag, ".idle_valid"}, 32'(if0.rsp_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.req_valid = '0; if0.req_a = '0; if0.req_b = '0; if0.rsp_ready = 1'b0;
    if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b1;

    // Reset and idle
    tick();
    check("rst.busy", 32'(busy0), 32'd0);
    check("rst.req_ready", 32'(if0.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle.rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("idle.busy", 32'(busy0), 32'd0);
    check("idle.ovf", 32'(ovf0), 32'd0);
    check("idle.req_ready", 32'(if0.req_ready), 32'd0);
    check("idle.rsp_sub", 32'(if0.rsp_sub), 32'd0);
    check("idle.ovf1", 32'(ovf1), 32'd0);

    // Single request and the three overflow corners
    do_op(2, 4'd3, 4'd5, "single");
    do_op(0, 4'd7, 4'hF, "ovf_7_m1");
    do_op(1, 4'h8, 4'd1, "ovf_m8_1");
    do_op(3, 4'd0, 4'h8, "ovf_0_m8");
    check("ovf.count3", 32'(ovf0), 32'd3);

    // Backpressure: response held for 5 cycles, then next grant in cycle 3
    if0.rsp_ready = 1'b0;
    set_req(1, 4'd2, 4'hD);
    #1;
    check("bp.grant", 32'(if0.req_ready), 32'b0010);
    push_exp(1, 4'd2, 4'hD);
    tick();
    clr_req(1);
    tick();
    check_rsp("bp");
    set_req(2, 4'd1, 4'd1);
    for (int c = 0; c < 5; c++) begin
      check("bp.hold_valid", 32'(if0.rsp_valid), 32'd1);
      check("bp.hold_sub", 32'(if0.rsp_sub), 32'd5);
      check("bp.hold_id", 32'(if0.rsp_id), 32'd1);
      check("bp.hold_flag", 32'(if0.rsp_flag), 32'd1);
      check("bp.no_ready", 32'(if0.req_ready), 32'd0);
      check("bp.busy", 32'(busy0), 32'd1);
      tick();
    end
    if0.rsp_ready = 1'b1;
    tick();
    check("bp.release_valid", 32'(if0.rsp_valid), 32'd0);
    check("bp.release_busy", 32'(busy0), 32'd0);
    check("bp.next_grant", 32'(if0.req_ready), 32'b0100);
    push_exp(2, 4'd1, 4'd1);
    tick();
    clr_req(2);
    tick();
    check_rsp("bp_next");
    tick();

    // All four requesters valid from reset: grants 0,1,2,3,0 every 3 cycles
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 4'(i + 2));
    tick();
    check("rr.rst_ready", 32'(if0.req_ready), 32'd0);
    check("rr.rst_busy", 32'(busy0), 32'd0);
    rst = 1'b0;
    exp_ovf0 = 0;
    sbq.delete();
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr.grant", 32'(if0.req_ready), 32'(1) << (g % 4));
      push_exp(g % 4, 4'(g % 4), 4'((g % 4) + 2));
      tick();
      tick();
      check_rsp("rr");
      tick();
    end
    if0.req_valid = '0;

    // Reset during EXEC discards the op and returns ptr to 0
    set_req(2, 4'd7, 4'hF);
    #1;
    check("rx.grant", 32'(if0.req_ready), 32'b0100);
    tick();
    check("rx.exec_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    clr_req(2);
    tick();
    check("rx.valid", 32'(if0.rsp_valid), 32'd0);
    check("rx.ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    exp_ovf0 = 0;
    set_req(1, 4'd4, 4'd1);
    set_req(3, 4'd1, 4'd1);
    #1;
    check("rx.ptr0_grant", 32'(if0.req_ready), 32'b0010);
    push_exp(1, 4'd4, 4'd1);
    tick();
    if0.req_valid = '0;
    tick();
    check_rsp("rx");
    tick();
    check("rx.idle", 32'(busy0), 32'd0);

    // Saturation of a 2-bit overflow counter
    for (int n = 1; n <= 5; n++) begin
      if1.req_valid   = 4'b0001;
      if1.req_a[3:0]  = 4'd7;
      if1.req_b[3:0]  = 4'hF;
      tick();
      if1.req_valid = '0;
      tick();
      check("sat.valid", 32'(if1.rsp_valid), 32'd1);
      check("sat.flag", 32'(if1.rsp_flag), 32'd0);
      check("sat.ovf", 32'(ovf1), (n < 3) ? n : 3);
      tick();
    end
    check("sat.final", 32'(ovf1), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
